// File: rtl/rom_seq_pkg.sv
// Shared types and default widths for the lab ROM sequencer.
package rom_seq_pkg;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_SUM_W  = 7;

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} seq_state_t;
endpackage

// File: rtl/rom_sequencer.sv
// Reads a run of ROM words from a start address (wrapping), streams them
// over valid/ready and keeps a running sum of accepted words.
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] start_addr_in,
  input  logic [ADDR_W:0]   len_in,
  output logic [ADDR_W-1:0] Rom_addr_out,
  input  logic [DATA_W-1:0] Rom_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [SUM_W-1:0]  sum_out,
  output logic              busy_out,
  output logic              done_out
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              vld_nxt;
  logic [SUM_W-1:0]  sum_nxt;
  logic [ADDR_W:0]   rem, rem_nxt;
  logic [ADDR_W:0]   len_c;

  assign len_c    = (len_in > MAX_LEN) ? MAX_LEN : len_in;
  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);

  always_comb begin
    state_nxt = state;
    addr_nxt  = Rom_addr_out;
    data_nxt  = data_out;
    vld_nxt   = valid_out;
    sum_nxt   = sum_out;
    rem_nxt   = rem;
    case (state)
      IDLE: begin
        if (start_in) begin
          sum_nxt = '0;
          if (len_c == '0) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = start_addr_in;
            rem_nxt   = len_c;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        data_nxt  = Rom_data_in;
        vld_nxt   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (valid_out && ready_in) begin
          sum_nxt = sum_out + SUM_W'(data_out);
          rem_nxt = rem - 1'b1;
          vld_nxt = 1'b0;
          // Address only advances when another word follows, so it holds the last one read.
          if (rem == 1) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = Rom_addr_out + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      Rom_addr_out <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      sum_out      <= '0;
      rem          <= '0;
    end else begin
      state        <= state_nxt;
      Rom_addr_out <= addr_nxt;
      data_out     <= data_nxt;
      valid_out    <= vld_nxt;
      sum_out      <= sum_nxt;
      rem          <= rem_nxt;
    end
  end
endmodule

// File: tb/tb_rom_sequencer.sv
// Self-checking bench: ROM model plus a queue-based reference of each run.
module tb_rom_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in;
  logic [2:0] start_addr_in;
  logic [3:0] len_in;
  logic [2:0] Rom_addr_out;
  logic [3:0] Rom_data_in;
  logic [3:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic [6:0] sum_out;
  logic       busy_out;
  logic       done_out;

  logic [3:0] rom [8];
  int compares   = 0;
  int mismatches = 0;

  always #5 clk = ~clk;
  assign Rom_data_in = rom[Rom_addr_out];

  rom_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .start_addr_in(start_addr_in),
    .len_in(len_in), .Rom_addr_out(Rom_addr_out), .Rom_data_in(Rom_data_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .sum_out(sum_out), .busy_out(busy_out), .done_out(done_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One run: expected words are rom[(sa+i) mod 8] for i < min(ln,8).
  task automatic run(input logic [2:0] sa, input logic [3:0] ln, input int rdy_pct,
                     input int xstart_c);
    logic [3:0] q[$];
    int n, exp_sum, c, first_v, last_hs, done_c, dones;
    bit pv, pr;
    logic [3:0] pd;
    n = (ln > 8) ? 8 : int'(ln);
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      q.push_back(rom[(int'(sa) + i) % 8]);
      exp_sum += int'(rom[(int'(sa) + i) % 8]);
    end
    @(negedge clk);
    check("idle_before_start", busy_out, 0);
    start_in = 1'b1; start_addr_in = sa; len_in = ln;
    ready_in = ($urandom_range(99) < rdy_pct);
    c = 0; first_v = -1; last_hs = -1; done_c = -1; dones = 0; pv = 0; pr = 0; pd = '0;
    while (done_c < 0 && c < 400) begin
      @(negedge clk);
      c++;
      start_in = (c == xstart_c);
      if (c == xstart_c) begin start_addr_in = 3'd0; len_in = 4'd1; end
      check("busy_in_run", busy_out, 1);
      if (pv && !pr) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, pd);
      end
      if (done_out) begin dones++; done_c = c; end
      if (valid_out && first_v < 0) first_v = c;
      ready_in = ($urandom_range(99) < rdy_pct);
      if (valid_out && ready_in) begin
        if (q.size() == 0) check("extra_word", 1, 0);
        else check("word", data_out, q.pop_front());
        last_hs = c;
      end
      pv = valid_out; pr = ready_in; pd = data_out;
    end
    start_in = 1'b0;
    check("done_seen", done_c > 0, 1);
    check("words_left", q.size(), 0);
    check("done_count", dones, 1);
    if (n > 0) begin
      check("first_valid_latency", first_v, 2);
      check("done_after_last", done_c, last_hs + 1);
      if (rdy_pct >= 100) check("full_rate_done", done_c, 2 * n + 1);
    end else begin
      check("zero_len_done", done_c, 1);
      check("zero_len_novalid", first_v, -1);
    end
    check("sum_at_done", sum_out, exp_sum);
    @(negedge clk);
    check("post_done", done_out, 0);
    check("post_busy", busy_out, 0);
    check("post_valid", valid_out, 0);
    check("post_sum_hold", sum_out, exp_sum);
  endtask

  initial begin
    int w;
    rom[0] = 4'd0; rom[1] = 4'd0; rom[2] = 4'd8; rom[3] = 4'd5;
    rom[4] = 4'd7; rom[5] = 4'd1; rom[6] = 4'd0; rom[7] = 4'd2;
    rst_n = 1'b0; start_in = 1'b0; start_addr_in = '0; len_in = '0; ready_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", Rom_addr_out, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_sum", sum_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    rst_n = 1'b1;

    run(3'd2, 4'd3, 100, 0);   // basic: 8,5,7 sum 20
    run(3'd6, 4'd4, 100, 0);   // wrap: 0,2,0,0 sum 2
    run(3'd0, 4'd8, 50, 0);    // sweep with backpressure, sum 23
    run(3'd0, 4'd0, 100, 0);   // zero length
    run(3'd3, 4'd15, 70, 0);   // clamped to 8
    run(3'd4, 4'd2, 100, 3);   // start during run ignored: 7,1 sum 8
    run(3'd5, 4'd2, 100, 5);   // start in DONE cycle ignored

    // Reset in the middle of a len=5 run, while a word is stalled.
    @(negedge clk);
    start_in = 1'b1; start_addr_in = 3'd0; len_in = 4'd5; ready_in = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    w = 0;
    while (!valid_out && w < 10) begin @(negedge clk); w++; end
    check("mid_run_valid", valid_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_addr", Rom_addr_out, 0);
    check("mrst_data", data_out, 0);
    check("mrst_valid", valid_out, 0);
    check("mrst_sum", sum_out, 0);
    check("mrst_busy", busy_out, 0);
    check("mrst_done", done_out, 0);
    @(negedge clk);
    check("mrst_no_done", done_out, 0);
    run(3'd3, 4'd1, 100, 0);   // single word 5

    for (int k = 0; k < 8; k++)
      run(3'($urandom_range(7)), 4'($urandom_range(15)), int'($urandom_range(100, 30)),
          int'($urandom_range(12)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
